// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcodes and
// parameter helpers used by the top level at elaboration time.
package pipe_addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   // Legal configurations: 1..width stages, width an exact multiple of stages.
   function automatic bit params_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One carry-chain chunk: CW-bit ripple of full adders. Overflow is taken
// from the carries into and out of the top bit of the chunk.
module addsub_chunk #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] x_i,
   input  logic [CW-1:0] y_i,
   input  logic          cin_i,
   output logic [CW-1:0] sum_o,
   output logic          cout_o,
   output logic          ovf_o
);

   logic [CW:0] carry;

   assign carry[0] = cin_i;

   for (genvar i = 0; i < CW; i++) begin : g_fa
      assign sum_o[i]     = x_i[i] ^ y_i[i] ^ carry[i];
      assign carry[i+1]   = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
   end

   assign cout_o = carry[CW];
   assign ovf_o  = carry[CW] ^ carry[CW-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES
// chunks with a register after each, under a global-stall valid/ready scheme.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] dinx_i,
   input  logic [WIDTH-1:0] diny_i,
   input  logic             sub_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   if (!params_ok(WIDTH, STAGES)) begin : g_param_check
      $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
   end

   logic adv;

   assign adv     = ready_i || !valid_o;
   assign ready_o = adv;

   // Iteration k computes chunk k. Each stage register only keeps the operand
   // bits still to be processed plus the sum chunks already produced.
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int REM = WIDTH - k * CW;

      logic [REM-1:0]      x_in;
      logic [REM-1:0]      y_in;
      logic                c_in;
      logic                v_in;
      logic [CW-1:0]       s_chk;
      logic                c_chk;
      logic                ovf_chk;

      if (k == 0) begin : g_src
         logic [CW-1:0] sum_d;

         assign x_in  = dinx_i;
         assign y_in  = (sub_i == OP_ADD) ? diny_i : ~diny_i;
         assign c_in  = (sub_i == OP_SUB);
         assign v_in  = valid_i;
         assign sum_d = s_chk;
      end else begin : g_src
         logic [(k+1)*CW-1:0] sum_d;

         assign x_in  = g_st[k-1].g_reg.x_q;
         assign y_in  = g_st[k-1].g_reg.y_q;
         assign c_in  = g_st[k-1].g_reg.c_q;
         assign v_in  = g_st[k-1].g_reg.v_q;
         assign sum_d = {s_chk, g_st[k-1].g_reg.s_q};
      end

      addsub_chunk #(
         .CW (CW)
      ) u_chunk (
         .x_i    (x_in[CW-1:0]),
         .y_i    (y_in[CW-1:0]),
         .cin_i  (c_in),
         .sum_o  (s_chk),
         .cout_o (c_chk),
         .ovf_o  (ovf_chk)
      );

      if (k < STAGES - 1) begin : g_reg
         logic [REM-CW-1:0]   x_q;
         logic [REM-CW-1:0]   y_q;
         logic [(k+1)*CW-1:0] s_q;
         logic                c_q;
         logic                v_q;
         logic                ovf_unused;

         // Only the final chunk's overflow is meaningful.
         assign ovf_unused = ovf_chk;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               x_q <= '0;
               y_q <= '0;
               s_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (adv) begin
               x_q <= x_in[REM-1:CW];
               y_q <= y_in[REM-1:CW];
               s_q <= g_src.sum_d;
               c_q <= c_chk;
               v_q <= v_in;
            end
         end
      end else begin : g_out
         logic [WIDTH-1:0] sum_q;
         logic             cout_q;
         logic             ovf_q;
         logic             valid_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               sum_q   <= '0;
               cout_q  <= 1'b0;
               ovf_q   <= 1'b0;
               valid_q <= 1'b0;
            end else if (adv) begin
               sum_q   <= g_src.sum_d;
               cout_q  <= c_chk;
               ovf_q   <= ovf_chk;
               valid_q <= v_in;
            end
         end
      end
   end

   assign valid_o = g_st[STAGES-1].g_out.valid_q;
   assign sum_o   = g_st[STAGES-1].g_out.sum_q;
   assign cout_o  = g_st[STAGES-1].g_out.cout_q;
   assign ovf_o   = g_st[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: four instances (STAGES 1, 2, 4, 16) share stimulus;
// each keeps its own scoreboard of expected {cout, sum, ovf}.
module tb_pipe_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        ready = 1'b1;
   logic [15:0] dx = '0;
   logic [15:0] dy = '0;
   logic        sub = 1'b0;

   logic        rdy_o  [4];
   logic        vo     [4];
   logic [15:0] sum_w  [4];
   logic        cout_w [4];
   logic        ovf_w  [4];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic int stages_of(input int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 4;
         default: return 16;
      endcase
   endfunction

   function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic s);
      logic [16:0] r;
      logic        o;
      if (s) r = {1'b0, x} + {1'b0, ~y} + 17'd1;
      else   r = {1'b0, x} + {1'b0, y};
      if (s) o = (x[15] != y[15]) && (r[15] != x[15]);
      else   o = (x[15] == y[15]) && (r[15] != x[15]);
      return {r[16], r[15:0], o};
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int STG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
      logic [17:0] sb_q [$];
      logic [17:0] e;
      int          acc_cnt = 0;

      pipe_addsub #(
         .WIDTH  (16),
         .STAGES (STG)
      ) u_dut (
         .clk_i   (clk),
         .rst_i   (rst),
         .valid_i (valid),
         .ready_o (rdy_o[g]),
         .dinx_i  (dx),
         .diny_i  (dy),
         .sub_i   (sub),
         .valid_o (vo[g]),
         .ready_i (ready),
         .sum_o   (sum_w[g]),
         .cout_o  (cout_w[g]),
         .ovf_o   (ovf_w[g])
      );

      always @(negedge clk) begin
         if (rst) begin
            sb_q.delete();
         end else begin
            if (vo[g] && ready) begin
               if (sb_q.size() == 0) begin
                  check($sformatf("extra_out_s%0d", STG), 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check($sformatf("sb_s%0d", STG),
                        {14'd0, cout_w[g], sum_w[g], ovf_w[g]}, {14'd0, e});
               end
            end
            if (valid && rdy_o[g]) begin
               sb_q.push_back(ref_model(dx, dy, sub));
               acc_cnt++;
            end
         end
      end
   end

   // One op into idle pipelines with ready=1; checks latency of every
   // instance and the STAGES=4 result against the given constants.
   task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic [15:0] es, input logic ec, input logic eo);
      int          lat [4];
      logic [17:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) lat[i] = -1;
      @(posedge clk); #1;
      valid = 1'b1; dx = x; dy = y; sub = s; ready = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         valid = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (vo[i] && lat[i] < 0) lat[i] = c;
         if (vo[2] && lat[2] == c) res = {cout_w[2], sum_w[2], ovf_w[2]};
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_lat_s%0d", tag, stages_of(i)), lat[i], stages_of(i));
      check({tag, "_sum"},  {16'd0, res[16:1]}, {16'd0, es});
      check({tag, "_cout"}, {31'd0, res[17]},   {31'd0, ec});
      check({tag, "_ovf"},  {31'd0, res[0]},    {31'd0, eo});
   endtask

   initial begin
      logic [17:0] held;
      int          idx;
      int          seen;
      int          start [4];
      bit          done;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_vo_s%0d",  stages_of(i)), vo[i],     0);
         check($sformatf("rst_sum_s%0d", stages_of(i)), sum_w[i],  0);
         check($sformatf("rst_co_s%0d",  stages_of(i)), cout_w[i], 0);
         check($sformatf("rst_ov_s%0d",  stages_of(i)), ovf_w[i],  0);
         check($sformatf("rst_rdy_s%0d", stages_of(i)), rdy_o[i],  1);
      end

      run_one("add1",  16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0);
      run_one("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("ovfa",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("sub1",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("ovfs",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_one("subw",  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

      // Back-pressure: 8 ops, ready_i low in cycles 6..8.
      idx  = 0;
      held = '0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk); #1;
         ready = !(cyc >= 6 && cyc < 9);
         valid = (idx < 8);
         dx    = 16'h1111 * idx[15:0] + 16'h00F0;
         dy    = 16'h0F0F ^ idx[15:0];
         sub   = idx[0];
         @(negedge clk);
         if (cyc == 6) begin
            check("stall_vo", vo[2], 1);
            held = {cout_w[2], sum_w[2], ovf_w[2]};
         end
         if (cyc >= 6 && cyc < 9) check($sformatf("stall_rdy_c%0d", cyc), rdy_o[2], 0);
         if (cyc == 7 || cyc == 8)
            check($sformatf("stall_hold_c%0d", cyc),
                  {14'd0, cout_w[2], sum_w[2], ovf_w[2]}, {14'd0, held});
         if (valid && rdy_o[2]) idx++;
      end
      valid = 1'b0;
      check("bp_all_sent", idx, 8);
      check("bp_drained", g_dut[2].sb_q.size(), 0);

      // Reset with three ops in flight.
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         valid = 1'b1; dx = 16'hA000 + i[15:0]; dy = 16'h0123; sub = 1'b0;
      end
      @(posedge clk); #1;
      valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("midrst_vo_s%0d", stages_of(i)), vo[i], 0);
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (vo[2]) seen++;
      end
      check("midrst_stale", seen, 0);

      // Random traffic until every instance has accepted 10k ops.
      start[0] = g_dut[0].acc_cnt; start[1] = g_dut[1].acc_cnt;
      start[2] = g_dut[2].acc_cnt; start[3] = g_dut[3].acc_cnt;
      done = 1'b0;
      for (int c = 0; c < 60000 && !done; c++) begin
         @(posedge clk); #1;
         valid = ($urandom_range(0, 9) < 7);
         ready = ($urandom_range(0, 9) < 7);
         sub   = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0: dx = 16'hFFFF;
            1: dx = 16'h8000;
            2: dx = 16'h7FFF;
            default: dx = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: dy = 16'h0001;
            1: dy = 16'hFFFF;
            2: dy = 16'h0000;
            default: dy = $urandom;
         endcase
         @(negedge clk);
         done = (g_dut[0].acc_cnt - start[0] >= 10000) && (g_dut[1].acc_cnt - start[1] >= 10000)
             && (g_dut[2].acc_cnt - start[2] >= 10000) && (g_dut[3].acc_cnt - start[3] >= 10000);
      end
      check("rand_budget", done, 1);

      @(posedge clk); #1;
      valid = 1'b0; ready = 1'b1;
      repeat (40) @(negedge clk);
      check("drain_s1",  g_dut[0].sb_q.size(), 0);
      check("drain_s2",  g_dut[1].sb_q.size(), 0);
      check("drain_s4",  g_dut[2].sb_q.size(), 0);
      check("drain_s16", g_dut[3].sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
